cl_secuencial: RTL and testbench
================================

# cl_secuencial

Parametrised multi-cycle logic cell: applies AND, OR, XOR or NOT-A to two WIDTH-bit operands, processing SLICE bits per clock cycle, with start/busy/done handshake and a registered zero flag. It is the word-level, sequential successor of the 1-bit combinational logic cell. It sits in the datapath as the logic unit beside the adder, so that narrow hardware can serve wide operands.

## Interface
- WIDTH, 8, operand/result width in bits; must be an integer multiple of SLICE.
- SLICE, 2, bits processed per cycle; N = WIDTH/SLICE run cycles per operation.
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled on a rising edge only while busy=0.
- a  input  WIDTH  operand A; captured at accepted start.
- b  input  WIDTH  operand B; captured at accepted start.
- s  input  2  operation, captured at accepted start: 00 AND, 01 OR, 10 XOR, 11 NOT a (b ignored).
- out  output  WIDTH  registered result of last completed operation.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse: out/zero just updated.
- zero  output  1  registered; 1 when out == 0.

## Operation
- States: IDLE, RUN.
- IDLE: busy=0. On an edge with start=1, go to RUN:
  - latch a, b and s into internal shift registers (opA, opB, opS);
  - clear slice counter cnt and result shift register acc.
- RUN: busy=1. Each edge:
  - compute op(opA[SLICE-1:0], opB[SLICE-1:0]) per bit;
  - shift it into acc from the MSB end (acc = {slice_result, acc[WIDTH-1:SLICE]});
  - shift opA and opB right by SLICE; cnt++.
- On the edge where cnt reaches N-1 (the Nth RUN edge):
  - out <= final acc value (result bit i = op(a[i], b[i]));
  - zero <= (that value == 0);
  - done <= 1; state -> IDLE.
- done is 1 for exactly one cycle; cleared on the next edge.
- out and zero hold their value between completions; they are never updated mid-run.
- cnt width = clog2(N), minimum 1 bit; wraps only through the reset to 0 at start.
- N=1 (SLICE=WIDTH): RUN lasts one edge; same handshake.

## Timing
- Start accepted at edge E0 -> busy=1 after E0 -> out/zero/done valid after edge E0+N -> busy=0 after E0+N.
- Latency: N cycles from the accepting edge to done. Throughput: one operation per N+1 cycles.
- Start can be accepted in the cycle where done=1, because busy=0 in that cycle.
- start=1 while busy=1: ignored; no queueing. Holding start high after done begins a new operation.
- a, b, s may change at any time after the accepting edge without affecting the running operation.
- reset=1 at any edge, including mid-RUN:
  - state=IDLE; out=0, zero=0, busy=0, done=0; acc, cnt, opA, opB, opS cleared;
  - an aborted operation never produces done.
- reset and start on the same edge: reset wins and start is dropped.
- Reset values: out=0, busy=0, done=0, zero=0.

## Test plan
- WIDTH=8, SLICE=2: a=0xA5, b=0x0F, s=00, start pulse -> busy 4 cycles, then done=1 for one cycle with out=0x05, zero=0.
- Same instance: s=10 gives out=0xAA. s=11 with b=0xFF gives out=0x5A (b ignored). s=01, a=0x00, b=0x00 gives out=0x00, zero=1.
- Back-to-back: start held high continuously -> an operation completes every 5 cycles; each done lasts one cycle; out is stable between dones.
- Mid-run interference: after acceptance, toggle start and change a, b and s every cycle -> result matches the operands captured at the accepting edge; no extra operation starts until busy=0.
- Reset at the 2nd RUN cycle -> the next cycle shows busy=0, out=0, done=0. No done appears later. A fresh start after reset completes correctly.
- Instance WIDTH=8, SLICE=8: a=0xF0, b=0x3C, s=10 -> done one cycle after the accepting edge, out=0xCC.

Source files
------------

// File: rtl/cl_secuencial.sv
// cl_secuencial: word-level logic cell (AND/OR/XOR/NOT-A) evaluated SLICE bits per cycle.
module cl_secuencial #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SLICE = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       s,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  localparam int unsigned N  = WIDTH / SLICE;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [1:0]       ops_q, ops_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;

  logic [SLICE-1:0] slice_res;
  logic [WIDTH-1:0] acc_next;

  always_comb begin
    slice_res = '0;
    case (ops_q)
      2'b00:   slice_res = opa_q[SLICE-1:0] & opb_q[SLICE-1:0];
      2'b01:   slice_res = opa_q[SLICE-1:0] | opb_q[SLICE-1:0];
      2'b10:   slice_res = opa_q[SLICE-1:0] ^ opb_q[SLICE-1:0];
      default: slice_res = ~opa_q[SLICE-1:0];
    endcase
  end

  // Shift-based insert at the MSB end stays legal when SLICE == WIDTH (N == 1).
  always_comb begin
    acc_next = (acc_q >> SLICE) | (WIDTH'(slice_res) << (WIDTH - SLICE));
  end

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    ops_d   = ops_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    zero_d  = zero_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          opa_d   = a;
          opb_d   = b;
          ops_d   = s;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        acc_d = acc_next;
        opa_d = opa_q >> SLICE;
        opb_d = opb_q >> SLICE;
        if (cnt_q == CW'(N - 1)) begin
          out_d   = acc_next;
          zero_d  = (acc_next == '0);
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      ops_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      ops_q   <= ops_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

  assign out  = out_q;
  assign zero = zero_q;
  assign done = done_q;
  assign busy = (state_q == RUN);

endmodule

// File: tb/tb_cl_secuencial.sv
// Bench for cl_secuencial: directed cases plus randomized operations against a word-level model.
module tb_cl_secuencial;

  logic       clk;
  logic       reset;
  logic       start2, start8;
  logic [7:0] a, b;
  logic [1:0] s;
  logic [7:0] out2, out8;
  logic       busy2, done2, zero2;
  logic       busy8, done8, zero8;

  bit         sel8;
  logic [7:0] o_out;
  logic       o_busy, o_done, o_zero;

  int unsigned total;
  int unsigned errs;

  cl_secuencial #(.WIDTH(8), .SLICE(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .a(a), .b(b), .s(s),
    .out(out2), .busy(busy2), .done(done2), .zero(zero2)
  );

  cl_secuencial #(.WIDTH(8), .SLICE(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a), .b(b), .s(s),
    .out(out8), .busy(busy8), .done(done8), .zero(zero8)
  );

  assign o_out  = sel8 ? out8  : out2;
  assign o_busy = sel8 ? busy8 : busy2;
  assign o_done = sel8 ? done8 : done2;
  assign o_zero = sel8 ? zero8 : zero2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] model(input logic [7:0] x, input logic [7:0] y,
                                       input logic [1:0] op);
    case (op)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~x;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input logic v);
    if (sel8) start8 = v;
    else      start2 = v;
  endtask

  task automatic run_op(input logic [7:0] xa, input logic [7:0] xb, input logic [1:0] xs,
                        input bit interfere, input int unsigned n);
    logic [7:0]  exp;
    logic [7:0]  prev;
    int unsigned cyc;
    bit          seen;
    exp  = model(xa, xb, xs);
    a    = xa;
    b    = xb;
    s    = xs;
    set_start(1'b1);
    tick();
    set_start(1'b0);
    check("busy_after_accept", o_busy, 1);
    prev = o_out;
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < n + 3) begin
      if (interfere) begin
        a = 8'($urandom);
        b = 8'($urandom);
        s = 2'($urandom);
        set_start(1'($urandom));
      end
      tick();
      cyc++;
      if (o_done) seen = 1;
      else check("out_hold_midrun", o_out, prev);
    end
    set_start(1'b0);
    check("done_seen", seen, 1);
    check("latency", cyc, n);
    check("out", o_out, exp);
    check("zero", o_zero, exp == 8'h00);
    check("busy_at_done", o_busy, 0);
    tick();
    check("done_one_cycle", o_done, 0);
    check("no_extra_op", o_busy, 0);
    check("out_stable", o_out, exp);
  endtask

  task automatic back_to_back(input int unsigned ops);
    logic [7:0] expcur, expnext, prev;
    sel8   = 0;
    a      = 8'($urandom);
    b      = 8'($urandom);
    s      = 2'($urandom);
    expcur = model(a, b, s);
    start2 = 1'b1;
    prev   = out2;
    tick();
    for (int unsigned op = 0; op < ops; op++) begin
      for (int unsigned c = 1; c <= 4; c++) begin
        tick();
        if (c < 4) begin
          check("b2b_no_done", done2, 0);
          check("b2b_out_hold", out2, prev);
        end else begin
          check("b2b_done", done2, 1);
          check("b2b_out", out2, expcur);
        end
      end
      a       = 8'($urandom);
      b       = 8'($urandom);
      s       = 2'($urandom);
      expnext = model(a, b, s);
      if (op == ops - 1) start2 = 1'b0;
      tick();
      check("b2b_done_pulse", done2, 0);
      check("b2b_out_kept", out2, expcur);
      check("b2b_restart", busy2, (op != ops - 1));
      prev   = expcur;
      expcur = expnext;
    end
  endtask

  initial begin
    total  = 0;
    errs   = 0;
    sel8   = 0;
    reset  = 1'b1;
    start2 = 1'b0;
    start8 = 1'b0;
    a      = '0;
    b      = '0;
    s      = '0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_out2",  out2,  0);
    check("rst_busy2", busy2, 0);
    check("rst_done2", done2, 0);
    check("rst_zero2", zero2, 0);
    check("rst_out8",  out8,  0);
    check("rst_busy8", busy8, 0);
    tick();

    run_op(8'hA5, 8'h0F, 2'b00, 0, 4);
    run_op(8'hA5, 8'h0F, 2'b10, 0, 4);
    run_op(8'hA5, 8'hFF, 2'b11, 0, 4);
    run_op(8'h00, 8'h00, 2'b01, 0, 4);
    run_op(8'hA5, 8'h0F, 2'b00, 1, 4);

    back_to_back(4);

    run_op(8'hC3, 8'h81, 2'b01, 0, 4);
    a      = 8'h12;
    b      = 8'h34;
    s      = 2'b01;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", busy2, 0);
    check("abort_out",  out2,  0);
    check("abort_done", done2, 0);
    check("abort_zero", zero2, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort_no_done", done2, 0);
    end
    run_op(8'h3C, 8'h5A, 2'b10, 0, 4);

    sel8 = 1;
    run_op(8'hF0, 8'h3C, 2'b10, 0, 1);
    for (int i = 0; i < 8; i++)
      run_op(8'($urandom), 8'($urandom), 2'($urandom), (i % 2) == 1, 1);

    sel8 = 0;
    for (int i = 0; i < 24; i++)
      run_op(8'($urandom), 8'($urandom), 2'($urandom), (i % 2) == 0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", total, errs);
    $finish;
  end

endmodule
